mdr_feeder: RTL and testbench
=============================

Name: mdr_feeder

Overview:
- Command sequencer directly upstream of the MDR multiply/divide/root unit.
- Accepts one complete command (op, X, Y) through a valid/ready handshake.
- Drives the MDR Start/Load/Op/Data protocol in response to its Load_X/Load_Y requests.
- Captures Result/Reminder/error into a held response register, so software-side logic never sequences MDR operand loads itself.

Parameters:
- W, 16, operand/result width; must match the MDR Data/Result width.
- LOAD_CYCLES, 2, number of clocks Load is held high per operand push (1..15).
- TIMEOUT_CYCLES, 1023, watchdog limit in clocks; used only with MDR_FEED_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  feeder can accept a command.
- cmd_op  in  2  0=multiply, 1=divide, 2=square root, 3=illegal.
- cmd_x  in  W  first operand (multiplicand / dividend / radicand).
- cmd_y  in  W  second operand (multiplier / divisor); ignored for op 2.
- Start  out  1  to MDR: operation active.
- Load  out  1  to MDR: Data is valid for loading.
- Op  out  2  to MDR: operation select.
- Data  out  W  to MDR: operand bus.
- error  in  1  from MDR: operation error (e.g. divide by zero).
- Load_X  in  1  from MDR: requesting X.
- Load_Y  in  1  from MDR: requesting Y.
- Ready  in  1  from MDR: Result/Reminder valid.
- Result  in  W  from MDR.
- Reminder  in  W  from MDR.
- rsp_valid  out  1  response held valid.
- rsp_ack  in  1  response consumed.
- rsp_result  out  W  captured Result.
- rsp_reminder  out  W  captured Reminder.
- rsp_error  out  1  MDR error, illegal op, or timeout.
- rsp_timeout  out  1  response was produced by the watchdog.

Behaviour:
- Reset (async, rst=1): state IDLE. Start, Load, Op, Data, rsp_* all 0. cmd_ready=1 on the first clock after release.
- cmd_ready = (state==IDLE) && !rsp_valid. There is only one outstanding command.
- Accept on cmd_valid && cmd_ready: op, X and Y are registered, and Op is driven from the register for the whole transaction.
- FSM states: IDLE, WAIT_X, PUSH_X, REL_X, WAIT_Y, PUSH_Y, REL_Y, WAIT_RDY.
  - IDLE: on accept with op 3, produce an immediate response (rsp_error=1, result/reminder 0, no MDR activity). On accept with op 0..2, go to WAIT_X.
  - Start=1 in every state from WAIT_X through WAIT_RDY inclusive.
  - WAIT_X: on Load_X=1, go to PUSH_X.
  - PUSH_X: Data=X, Load=1 for exactly LOAD_CYCLES clocks (counter), then REL_X.
  - REL_X: Load=0, Data held at X; wait for Load_X=0. Then go to WAIT_Y for ops 0/1, or WAIT_RDY for op 2.
  - WAIT_Y, PUSH_Y, REL_Y: same as the X states, using Load_Y and Y; then WAIT_RDY.
  - WAIT_RDY: on Ready=1, capture Result, Reminder and error into rsp_*, set rsp_valid=1, drop Start, go to IDLE.
- If Load_Y is asserted during WAIT_X, it is ignored; X is always loaded first.
- If Ready is seen before all required operands are pushed, capture it as in WAIT_RDY and force rsp_error=1.
- rsp_valid holds until a clock with rsp_ack=1. It clears on that edge; cmd_ready rises the same cycle.
- rsp_ack while rsp_valid=0 is ignored.
- rst mid-transaction: Start and Load drop asynchronously, any pending response is discarded, and the FSM returns to IDLE.

Optional Feature:
- MDR_FEED_TIMEOUT_EN defined: a counter runs in every non-IDLE state and resets on each state change.
  - On reaching TIMEOUT_CYCLES: abort the transaction (Start=0, Load=0), set rsp_valid=1, rsp_error=1, rsp_timeout=1, result/reminder 0, and return to IDLE.
- MDR_FEED_TIMEOUT_EN undefined: no counter; the feeder waits indefinitely; rsp_timeout is tied to 0.

Test Plan:
- Multiply: op=0, X=3, Y=5 -> X then Y pushed with Load high 2 clocks each; rsp_result=15, rsp_reminder=0, rsp_error=0.
- Divide: op=1, X=172, Y=3 -> rsp_result=57, rsp_reminder=1. Holding rsp_ack=0 for 20 clocks -> rsp_valid stays 1 and cmd_ready stays 0 throughout.
- Root: op=2, X=314 -> exactly one Load pulse issued, Y never pushed; rsp_result=17, rsp_reminder=25.
- Illegal op=3 and divide-by-zero (op=1, X=9, Y=0):
  - op=3 -> immediate rsp_error=1, Start never asserted.
  - divide-by-zero -> rsp_error=1 taken from the MDR error output.
- Reset mid-operation: rst=1 during PUSH_Y -> Start=0 and Load=0 within the same cycle. After release, a new command 4*6 -> rsp_result=24.
- With MDR_FEED_TIMEOUT_EN and TIMEOUT_CYCLES=50, the MDR model never asserts Ready -> on cycle 50 of WAIT_RDY, rsp_timeout=1, rsp_error=1, Start=0.

Source files
------------

// File: rtl/mdr_feeder.sv
// Command sequencer in front of the MDR unit: takes one (op, X, Y) command, drives the
// Start/Load/Op/Data operand protocol and holds the MDR response. Optional watchdog: MDR_FEED_TIMEOUT_EN.
//
// state      | meaning
// -----------+---------------------------------------------------
// S_IDLE     | no transaction; accepts a command when no response is held
// S_WAIT_X   | Start high, waiting for the MDR to request X
// S_PUSH_X   | Data=X with Load high for LOAD_CYCLES clocks
// S_REL_X    | Load low, Data held at X, waiting for Load_X to drop
// S_WAIT_Y   | waiting for the MDR to request Y (multiply/divide only)
// S_PUSH_Y   | Data=Y with Load high for LOAD_CYCLES clocks
// S_REL_Y    | Load low, Data held at Y, waiting for Load_Y to drop
// S_WAIT_RDY | all operands pushed, waiting for Ready
module mdr_feeder #(
    parameter int W              = 16,
    parameter int LOAD_CYCLES    = 2,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [1:0]   cmd_op,
    input  logic [W-1:0] cmd_x,
    input  logic [W-1:0] cmd_y,
    output logic         Start,
    output logic         Load,
    output logic [1:0]   Op,
    output logic [W-1:0] Data,
    input  logic         error,
    input  logic         Load_X,
    input  logic         Load_Y,
    input  logic         Ready,
    input  logic [W-1:0] Result,
    input  logic [W-1:0] Reminder,
    output logic         rsp_valid,
    input  logic         rsp_ack,
    output logic [W-1:0] rsp_result,
    output logic [W-1:0] rsp_reminder,
    output logic         rsp_error,
    output logic         rsp_timeout
);

    if (LOAD_CYCLES < 1 || LOAD_CYCLES > 15 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("mdr_feeder: LOAD_CYCLES must be 1..15 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_X, S_PUSH_X, S_REL_X, S_WAIT_Y, S_PUSH_Y, S_REL_Y, S_WAIT_RDY
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [1:0]     r_op;
    logic [W-1:0]   r_x;
    logic [W-1:0]   r_y;
    logic [3:0]     r_cnt;
    logic           r_rsp_valid;
    logic [W-1:0]   r_rsp_result;
    logic [W-1:0]   r_rsp_reminder;
    logic           r_rsp_error;

    logic           w_accept;
    logic           w_cnt_load;
    logic           w_early;
    logic           w_start;
    logic           w_load;
    logic [W-1:0]   w_data;
    logic           w_rsp_set;
    logic [W-1:0]   w_rsp_res;
    logic [W-1:0]   w_rsp_rem;
    logic           w_rsp_err;

`ifdef MDR_FEED_TIMEOUT_EN
    localparam int WDW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [WDW-1:0] r_wd;
    logic           w_wd_tc;
    logic           w_rsp_to;
    logic           r_rsp_timeout;
    assign w_wd_tc = (r_state != S_IDLE) && (r_wd == '0);
`endif

    assign cmd_ready = (r_state == S_IDLE) && !r_rsp_valid;
    assign w_accept  = cmd_valid && cmd_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_load  = 1'b0;
        w_early     = 1'b0;
        w_start     = 1'b0;
        w_load      = 1'b0;
        w_data      = '0;
        w_rsp_set   = 1'b0;
        w_rsp_res   = '0;
        w_rsp_rem   = '0;
        w_rsp_err   = 1'b0;
`ifdef MDR_FEED_TIMEOUT_EN
        w_rsp_to    = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (cmd_op == 2'd3) begin
                        w_rsp_set = 1'b1;
                        w_rsp_err = 1'b1;
                    end else begin
                        w_state_nxt = S_WAIT_X;
                    end
                end
            end
            S_WAIT_X: begin
                w_start = 1'b1;
                w_early = 1'b1;
                if (Load_X) begin
                    w_state_nxt = S_PUSH_X;
                    w_cnt_load  = 1'b1;
                end
            end
            S_PUSH_X: begin
                w_start = 1'b1;
                w_load  = 1'b1;
                w_data  = r_x;
                w_early = 1'b1;
                if (r_cnt == '0) w_state_nxt = S_REL_X;
            end
            S_REL_X: begin
                w_start = 1'b1;
                w_data  = r_x;
                w_early = (r_op != 2'd2);
                if (!Load_X) w_state_nxt = (r_op == 2'd2) ? S_WAIT_RDY : S_WAIT_Y;
            end
            S_WAIT_Y: begin
                w_start = 1'b1;
                w_early = 1'b1;
                if (Load_Y) begin
                    w_state_nxt = S_PUSH_Y;
                    w_cnt_load  = 1'b1;
                end
            end
            S_PUSH_Y: begin
                w_start = 1'b1;
                w_load  = 1'b1;
                w_data  = r_y;
                w_early = 1'b1;
                if (r_cnt == '0) w_state_nxt = S_REL_Y;
            end
            S_REL_Y: begin
                w_start = 1'b1;
                w_data  = r_y;
                if (!Load_Y) w_state_nxt = S_WAIT_RDY;
            end
            S_WAIT_RDY: begin
                w_start = 1'b1;
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // Ready ends any active transaction; it is only an error if operands are still missing.
        if (r_state != S_IDLE && Ready) begin
            w_state_nxt = S_IDLE;
            w_rsp_set   = 1'b1;
            w_rsp_res   = Result;
            w_rsp_rem   = Reminder;
            w_rsp_err   = error || w_early;
        end
`ifdef MDR_FEED_TIMEOUT_EN
        else if (w_wd_tc) begin
            w_state_nxt = S_IDLE;
            w_rsp_set   = 1'b1;
            w_rsp_err   = 1'b1;
            w_rsp_to    = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_op    <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_op <= cmd_op;
                r_x  <= cmd_x;
                r_y  <= cmd_y;
            end
            if (w_cnt_load)
                r_cnt <= 4'(LOAD_CYCLES - 1);
            else if (r_cnt != '0)
                r_cnt <= r_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_valid    <= 1'b0;
            r_rsp_result   <= '0;
            r_rsp_reminder <= '0;
            r_rsp_error    <= 1'b0;
        end else if (w_rsp_set) begin
            r_rsp_valid    <= 1'b1;
            r_rsp_result   <= w_rsp_res;
            r_rsp_reminder <= w_rsp_rem;
            r_rsp_error    <= w_rsp_err;
        end else if (r_rsp_valid && rsp_ack) begin
            r_rsp_valid    <= 1'b0;
        end
    end

`ifdef MDR_FEED_TIMEOUT_EN
    // Watchdog reloads on every state change, so each state gets the full TIMEOUT_CYCLES budget.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wd          <= WDW'(TIMEOUT_CYCLES - 1);
            r_rsp_timeout <= 1'b0;
        end else begin
            if (r_state == S_IDLE || w_state_nxt != r_state)
                r_wd <= WDW'(TIMEOUT_CYCLES - 1);
            else if (r_wd != '0)
                r_wd <= r_wd - 1'b1;
            if (w_rsp_set)
                r_rsp_timeout <= w_rsp_to;
        end
    end
    assign rsp_timeout = r_rsp_timeout;
`else
    assign rsp_timeout = 1'b0;
`endif

    assign Start        = w_start;
    assign Load         = w_load;
    assign Op           = r_op;
    assign Data         = w_data;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_result   = r_rsp_result;
    assign rsp_reminder = r_rsp_reminder;
    assign rsp_error    = r_rsp_error;

endmodule

// File: tb/tb_mdr_feeder.sv
// Directed bench for mdr_feeder with a behavioural MDR model; expected responses go through a scoreboard queue.
// Build with MDR_FEED_TIMEOUT_EN defined to also exercise the watchdog.
module tb_mdr_feeder;

    localparam int W  = 16;
    localparam int LC = 2;
    localparam int TO = 50;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid, cmd_ready;
    logic [1:0]   cmd_op;
    logic [W-1:0] cmd_x, cmd_y;
    logic         Start, Load;
    logic [1:0]   Op;
    logic [W-1:0] Data;
    logic         error, Load_X, Load_Y, Ready;
    logic [W-1:0] Result, Reminder;
    logic         rsp_valid, rsp_ack, rsp_error, rsp_timeout;
    logic [W-1:0] rsp_result, rsp_reminder;

    mdr_feeder #(.W(W), .LOAD_CYCLES(LC), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_x(cmd_x), .cmd_y(cmd_y),
        .Start(Start), .Load(Load), .Op(Op), .Data(Data),
        .error(error), .Load_X(Load_X), .Load_Y(Load_Y), .Ready(Ready), .Result(Result), .Reminder(Reminder),
        .rsp_valid(rsp_valid), .rsp_ack(rsp_ack), .rsp_result(rsp_result), .rsp_reminder(rsp_reminder),
        .rsp_error(rsp_error), .rsp_timeout(rsp_timeout)
    );

    always #5 clk = ~clk;

    // Behavioural MDR: requests X (then Y), latches Data on Load, answers one clock after the last release.
    int           m_st;
    logic [W-1:0] m_x, m_y;
    logic         m_never_ready;
    logic [31:0]  m_prod;

    function automatic logic [W-1:0] isqrt(input logic [W-1:0] v);
        int r = 0;
        while ((r + 1) * (r + 1) <= int'(v)) r++;
        return W'(r);
    endfunction

    assign m_prod = 32'(m_x) * 32'(m_y);

    always @(posedge clk or posedge rst) begin
        if (rst || !Start) begin
            m_st <= 0; Load_X <= 1'b0; Load_Y <= 1'b0; Ready <= 1'b0;
            error <= 1'b0; Result <= '0; Reminder <= '0;
        end else begin
            case (m_st)
                0: begin Load_X <= 1'b1; m_st <= 1; end
                1: if (Load) begin m_x <= Data; m_st <= 2; end
                2: if (!Load) begin
                       Load_X <= 1'b0;
                       if (Op == 2'd2) m_st <= 5;
                       else begin Load_Y <= 1'b1; m_st <= 3; end
                   end
                3: if (Load) begin m_y <= Data; m_st <= 4; end
                4: if (!Load) begin Load_Y <= 1'b0; m_st <= 5; end
                5: if (!m_never_ready) begin
                       Ready <= 1'b1;
                       m_st  <= 6;
                       case (Op)
                           2'd0: begin Result <= m_prod[W-1:0]; Reminder <= m_prod[2*W-1:W]; end
                           2'd1: if (m_y == '0) begin error <= 1'b1; Result <= '0; Reminder <= '0; end
                                 else begin Result <= m_x / m_y; Reminder <= m_x % m_y; end
                           default: begin Result <= isqrt(m_x); Reminder <= m_x - isqrt(m_x) * isqrt(m_x); end
                       endcase
                   end
                default: ;
            endcase
        end
    end

    int   load_clks = 0, load_pulses = 0, start_clks = 0;
    logic load_prev = 1'b0;
    always @(posedge clk) begin
        if (Load) load_clks <= load_clks + 1;
        if (Load && !load_prev) load_pulses <= load_pulses + 1;
        if (Start) start_clks <= start_clks + 1;
        load_prev <= Load;
    end

    typedef struct {
        logic [W-1:0] res;
        logic [W-1:0] rem;
        logic         err;
        logic         tmo;
    } exp_t;
    exp_t sb[$];

    int passed = 0, total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                            input bit push, input exp_t e);
        int n = 0;
        while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
        chk("cmd_ready_before_send", 32'(cmd_ready), 32'd1);
        if (push) sb.push_back(e);
        cmd_valid = 1'b1; cmd_op = op; cmd_x = x; cmd_y = y;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, input int hold);
        int   n = 0;
        exp_t e;
        while (!rsp_valid && n < 500) begin @(negedge clk); n++; end
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "_hold_valid_notready"}, {30'd0, rsp_valid, cmd_ready}, 32'b10);
        end
        chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_result"},   32'(rsp_result),   32'(e.res));
            chk({tag, "_reminder"}, 32'(rsp_reminder), 32'(e.rem));
            chk({tag, "_error"},    32'(rsp_error),    32'(e.err));
            chk({tag, "_timeout"},  32'(rsp_timeout),  32'(e.tmo));
        end
        rsp_ack = 1'b1;
        @(negedge clk);
        rsp_ack = 1'b0;
        chk({tag, "_ack_clears"}, {30'd0, rsp_valid, cmd_ready}, 32'b01);
    endtask

    initial begin
        int lc0, lp0, sc0, n;
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_x = '0; cmd_y = '0; rsp_ack = 1'b0;
        m_never_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", {26'd0, Start, Load, Op, rsp_valid, rsp_error}, 32'd0);
        chk("reset_data",    32'({Data, rsp_result}), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("cmd_ready_after_reset", 32'(cmd_ready), 32'd1);

        // stray ack while idle must be ignored
        rsp_ack = 1'b1; @(negedge clk); rsp_ack = 1'b0;
        chk("idle_ack_ignored", {30'd0, rsp_valid, cmd_ready}, 32'b01);

        lc0 = load_clks; lp0 = load_pulses;
        send_cmd(2'd0, 16'd3, 16'd5, 1'b1, '{16'd15, 16'd0, 1'b0, 1'b0});
        wait_rsp("mul_3x5", 0);
        chk("mul_load_clks",   32'(load_clks - lc0),   32'(2 * LC));
        chk("mul_load_pulses", 32'(load_pulses - lp0), 32'd2);

        send_cmd(2'd1, 16'd172, 16'd3, 1'b1, '{16'd57, 16'd1, 1'b0, 1'b0});
        wait_rsp("div_172_3", 20);

        lc0 = load_clks; lp0 = load_pulses;
        send_cmd(2'd2, 16'd314, 16'd999, 1'b1, '{16'd17, 16'd25, 1'b0, 1'b0});
        wait_rsp("sqrt_314", 0);
        chk("sqrt_load_clks",   32'(load_clks - lc0),   32'(LC));
        chk("sqrt_load_pulses", 32'(load_pulses - lp0), 32'd1);

        sc0 = start_clks;
        send_cmd(2'd3, 16'd7, 16'd7, 1'b1, '{16'd0, 16'd0, 1'b1, 1'b0});
        chk("illegal_immediate", 32'(rsp_valid), 32'd1);
        wait_rsp("illegal_op", 0);
        chk("illegal_no_start", 32'(start_clks - sc0), 32'd0);

        send_cmd(2'd1, 16'd9, 16'd0, 1'b1, '{16'd0, 16'd0, 1'b1, 1'b0});
        wait_rsp("div_by_zero", 0);

        // reset in PUSH_Y: pending command discarded, nothing pushed to the scoreboard
        send_cmd(2'd0, 16'd7, 16'd9, 1'b0, '{16'd0, 16'd0, 1'b0, 1'b0});
        n = 0;
        while (!(Load && Load_Y) && n < 200) begin @(negedge clk); n++; end
        chk("reached_push_y", {30'd0, Load, Load_Y}, 32'b11);
        #1 rst = 1'b1;
        #1 chk("rst_async_drop", {29'd0, Start, Load, rsp_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("after_rst_ready", {30'd0, cmd_ready, rsp_valid}, 32'b10);
        send_cmd(2'd0, 16'd4, 16'd6, 1'b1, '{16'd24, 16'd0, 1'b0, 1'b0});
        wait_rsp("mul_4x6_after_rst", 0);

`ifdef MDR_FEED_TIMEOUT_EN
        m_never_ready = 1'b1;
        send_cmd(2'd0, 16'd2, 16'd3, 1'b1, '{16'd0, 16'd0, 1'b1, 1'b1});
        n = 0;
        while (m_st != 5 && n < 200) begin @(negedge clk); n++; end
        chk("timeout_reached_wait", 32'(m_st), 32'd5);
        // next posedge enters WAIT_RDY; the watchdog fires on its TO-th clock there
        repeat (TO) @(posedge clk);
        @(negedge clk);
        chk("timeout_not_early", {30'd0, rsp_valid, Start}, 32'b01);
        @(negedge clk);
        chk("timeout_fires", {28'd0, rsp_valid, rsp_timeout, rsp_error, Start}, 32'b1110);
        chk("timeout_load_low", 32'(Load), 32'd0);
        wait_rsp("timeout", 0);
        m_never_ready = 1'b0;
`endif

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
